ram8_reader: RTL and testbench
==============================

RAM8_READER -- requirements
Module: ram8_reader

Interface
REQ-001 Parameter: WIDTH, default 16, word width of every storage entry and of in/out_data.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in  input  WIDTH  write data.
REQ-005 load  input  1  write enable; in is written to entry address at the edge.
REQ-006 address  input  3  write address, entries 0..7.
REQ-007 start  input  1  request a full sequential read-out of entries 0..7.
REQ-008 out_data  output  WIDTH  current read-out word, registered.
REQ-009 out_valid  output  1  out_data holds a word awaiting transfer.
REQ-010 out_ready  input  1  sink accepts word; transfer = out_valid & out_ready at an edge.
REQ-011 busy  output  1  read-out in progress.
REQ-012 done  output  1  one-cycle pulse after the final word (entry 7) transfers.

Function
REQ-013 Storage: 8 x WIDTH registers; load=1 at edge writes in to mem[address]; writes accepted in every state.
REQ-014 FSM states: IDLE, SEND; 3-bit read pointer ptr.
REQ-015 IDLE: busy=0, out_valid=0; start=1 at edge -> ptr=0, out_data=mem[0], out_valid=1, busy=1, state SEND.
REQ-016 Latency: start sampled at edge N -> out_valid=1 with mem[0] visible after edge N (cycle N+1).
REQ-017 SEND, no transfer at edge: out_data, out_valid, ptr held unchanged (out_data stable while stalled).
REQ-018 SEND, transfer with ptr<7: ptr=ptr+1, out_data=mem[ptr+1], out_valid stays 1 (back-to-back, one word per cycle at full throughput).
REQ-019 SEND, transfer with ptr=7: out_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
REQ-020 done=0 in all other cycles.
REQ-021 start while busy=1 ignored; no restart, no pointer change.
REQ-022 start in the cycle after done (state IDLE) begins a new read-out normally.
REQ-023 Fetch reads pre-edge memory: if load writes mem[k] at the same edge that fetches entry k, out_data gets the old value.
REQ-024 Write to entry already fetched into out_data does not alter out_data; write to a later entry is visible when that entry is fetched.
REQ-025 ptr wraps never; read-out always terminates after entry 7.
REQ-026 out_valid stays 1 from first word until final transfer; never deasserts mid-dump without reset.

Reset
REQ-027 reset=1 at edge: all 8 entries=0, state IDLE, ptr=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-028 reset has priority over load and start in the same cycle; neither takes effect.
REQ-029 reset during SEND aborts the read-out; no done pulse issued.

Verification
REQ-030 Reset, write mem[i]=16'h1000+i for i=0..7, start with out_ready=1 -> words 16'h1000..16'h1007 on 8 consecutive cycles, done pulse on cycle after 16'h1007 transfers, busy=0.
REQ-031 Same data, out_ready toggling 1,0,0,1,... -> each word held stable while out_ready=0; sequence and count unchanged; exactly one done pulse.
REQ-032 During read-out, at ptr=2 write mem[2]=16'hAAAA and mem[5]=16'h5555 -> out_data for entry 2 keeps old value, entry 5 emitted as 16'h5555.
REQ-033 start pulsed at ptr=3 -> ignored; exactly 8 words and one done.
REQ-034 reset asserted at ptr=4 with load=1, start=1 -> next cycle all outputs 0, no done; subsequent start dumps eight 16'h0000 words.
REQ-035 start in cycle immediately after done -> second full read-out of current contents starts with mem[0] one cycle later.

Source files
------------

// File: rtl/ram8_reader.sv
// Eight-entry register file with a sequential read-out port.
// After start, entries 0..7 stream out over a valid/ready handshake, then done pulses once.
module ram8_reader #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             dbg_state_o,
    output logic [2:0]       dbg_ptr_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    logic [2:0]       ptr_q;
    logic [WIDTH-1:0] mem_q [0:7];
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;

    // Handshake: a word moves when out_valid and out_ready are both high at a
    // rising edge; while out_valid is high and out_ready low, out_data is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                mem_q[address] <= in;
            end
            // Fetches read mem_q before this edge's write lands, so a same-edge
            // write to the fetched entry yields the old value.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q       <= 3'd0;
                        out_data_q  <= mem_q[0];
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (out_valid_q && out_ready) begin
                        if (ptr_q == 3'd7) begin
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            ptr_q      <= ptr_q + 3'd1;
                            out_data_q <= mem_q[ptr_q + 3'd1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_ram8_reader.sv
// Directed bench for ram8_reader: fills memory, runs read-outs under several
// out_ready patterns and mid-dump disturbances, and checks every word.
module tb_ram8_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic        start;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        dbg_state_o;
    logic [2:0]  dbg_ptr_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] img [8];
    logic [15:0] exp_q [$];

    ram8_reader #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .address(address),
        .start(start), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done),
        .dbg_state_o(dbg_state_o), .dbg_ptr_o(dbg_ptr_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        load = 1'b1; address = a; in = d;
        img[a] = d;
        tick();
        load = 1'b0;
    endtask

    task automatic load_exp();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(img[i]);
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready 1,0,0 repeating.
    // hook 1: writes at ptr=2/3; hook 2: start at ptr=3; hook 3: reset at ptr=4.
    task automatic dump(input int mode, input int hook, input bit skip_start, input bit restart);
        int          n;
        int          c;
        int          ndone;
        bit          xfer;
        bit          aborted;
        logic [15:0] held;
        n = 0; c = 0; ndone = 0; aborted = 1'b0;
        if (!skip_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check_eq("first_valid", out_valid, 1);
        check_eq("first_busy", busy, 1);
        while (ndone == 0 && c < 64) begin
            load = 1'b0; start = 1'b0;
            out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            check_eq("valid_held", out_valid, 1);
            if (hook == 1 && n == 2) begin
                check_eq("ptr_dbg", dbg_ptr_o, 2);
                load = 1'b1; address = 3'd2; in = 16'hAAAA; img[2] = 16'hAAAA;
            end
            if (hook == 1 && n == 3) begin
                load = 1'b1; address = 3'd5; in = 16'h5555; img[5] = 16'h5555;
            end
            if (hook == 2 && n == 3) start = 1'b1;
            if (hook == 3 && n == 4) begin
                reset = 1'b1; load = 1'b1; address = 3'd5; in = 16'hFFFF; start = 1'b1;
                tick();
                reset = 1'b0; load = 1'b0; start = 1'b0;
                check_eq("rst_valid", out_valid, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_data", out_data, 0);
                for (int i = 0; i < 8; i++) img[i] = 16'h0000;
                aborted = 1'b1;
                break;
            end
            held = out_data;
            xfer = out_valid && out_ready;
            if (xfer) begin
                if (exp_q.size() == 0) check_eq("extra_word", 1, 0);
                else check_eq("word", out_data, exp_q.pop_front());
                n++;
            end
            tick();
            c++;
            if (!xfer) check_eq("stall_hold", out_data, held);
            if (done) ndone++;
        end
        load = 1'b0; start = 1'b0;
        if (aborted) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check_eq("abort_no_done", done, 0);
                check_eq("abort_idle", out_valid, 0);
            end
            exp_q.delete();
        end else begin
            check_eq("done_seen", ndone, 1);
            check_eq("words_left", exp_q.size(), 0);
            if (mode == 0) check_eq("cycles", c, 8);
            check_eq("end_busy", busy, 0);
            check_eq("end_valid", out_valid, 0);
            if (restart) start = 1'b1;
            tick();
            start = 1'b0;
            check_eq("done_1cyc", done, 0);
            if (restart) check_eq("restart_valid", out_valid, 1);
        end
    endtask

    initial begin
        reset = 1'b1; in = '0; load = 1'b0; address = '0; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) img[i] = 16'h0000;
        tick();
        tick();
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_data", out_data, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) write_word(3'(i), 16'h1000 + 16'(i));

        // Full-throughput read-out.
        load_exp();
        dump(0, 0, 1'b0, 1'b0);

        // Stalled read-out.
        load_exp();
        dump(1, 0, 1'b0, 1'b0);

        // Writes during read-out: entry 2 already fetched, entry 5 not yet.
        load_exp();
        exp_q[5] = 16'h5555;
        dump(0, 1, 1'b0, 1'b0);

        // Start while busy is ignored.
        load_exp();
        dump(0, 2, 1'b0, 1'b0);

        // Start right after done begins a second read-out.
        load_exp();
        dump(0, 0, 1'b0, 1'b1);
        load_exp();
        dump(0, 0, 1'b1, 1'b0);

        // Reset mid-dump with load and start also high, then dump zeros.
        load_exp();
        dump(0, 3, 1'b0, 1'b0);
        load_exp();
        dump(0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
